// File: rtl/seq_det_ctrl.sv
// Controller for a programmable serial sequence detector.
// Holds the pattern/length/mode configuration, arms and disarms detection,
// counts matches up to a target, and flags a timeout when matches stop coming.
//
// Handshake: there is no back-pressure. A bit is consumed on every rising
// clk edge where din_valid=1 while the controller is ARMED. start/abort/cfg_we
// are single-cycle strobes sampled on the rising edge; abort beats start.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout_err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_DONE  = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Configuration registers
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [TMO_W-1:0] tmo_q;

  // Detection datapath: only the newest PAT_W-1 bits need storing, the
  // incoming bit completes the PAT_W-wide window.
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [TMO_W-1:0] timer_q;

  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic [CNT_W-1:0] count_inc;
  logic [TMO_W-1:0] timer_inc;
  logic             sample_match;
  logic             target_hit;
  logic             timer_hit;
  logic             arm;

  // Clamp the requested length into 1..PAT_W before it is stored
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  // Candidate next values and the match/target/timeout decisions for ARMED
  always_comb begin
    hist_shift   = {hist_q, din};
    len_mask     = ~({PAT_W{1'b1}} << len_q);
    fill_inc     = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    sample_match = din_valid && (fill_inc == len_q) &&
                   (((hist_shift ^ pat_q) & len_mask) == '0);
    count_inc    = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    target_hit   = sample_match && (tgt_q != '0) && (count_inc == tgt_q);
    timer_inc    = timer_q + TMO_W'(1);
    timer_hit    = (tmo_q != '0) && (timer_inc == tmo_q);
    arm          = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort takes priority over every other event
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_ARMED;
        S_ARMED: begin
          if (target_hit)                      state_d = S_DONE;
          else if (!sample_match && timer_hit) state_d = S_ERROR;
        end
        S_DONE:  if (start) state_d = S_ARMED;
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy        = (state_q == S_ARMED);
    done        = (state_q == S_DONE);
    timeout_err = (state_q == S_ERROR);
    state_o     = state_q;
  end

  // Configuration capture, only while IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= PAT_W'(8'b0011_0110);
      len_q <= LEN_W'(6);
      ovl_q <= 1'b1;
      tgt_q <= CNT_W'(1);
      tmo_q <= '0;
    end else if (cfg_we && (state_q == S_IDLE)) begin
      pat_q <= cfg_pattern;
      len_q <= len_clamped;
      ovl_q <= cfg_overlap;
      tgt_q <= cfg_target;
      tmo_q <= cfg_timeout;
    end
  end

  // History, fill, match counter, timer and the registered match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      timer_q     <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      if (arm) begin
        hist_q      <= '0;
        fill_q      <= '0;
        timer_q     <= '0;
        match_count <= '0;
      end else if ((state_q == S_ARMED) && !abort) begin
        if (din_valid) begin
          hist_q <= hist_shift[PAT_W-2:0];
          // Non-overlapping mode restarts the fill; old history is then ignored
          fill_q <= (sample_match && !ovl_q) ? '0 : fill_inc;
        end
        if (sample_match) begin
          match_count <= count_inc;
          timer_q     <= '0;
          match_pulse <= 1'b1;
        end else begin
          timer_q <= timer_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [TMO_W-1:0] cfg_timeout = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             timeout_err;
  logic [1:0]       state_o;

  int checks = 0;
  int failures = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .din_valid(din_valid), .din(din), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done), .timeout_err(timeout_err),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: bits since the last arm (or non-overlapping match) kept
  // in a queue; a match is the tail of the queue spelling the pattern.
  localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2, M_ERROR = 3;
  int          m_state;
  logic [7:0]  m_pat;
  int          m_len, m_tgt, m_tmo, m_count, m_quiet;
  bit          m_ovl, m_pulse;
  bit          m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tail_matches();
    if (m_q.size() < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++)
      if (m_q[m_q.size() - 1 - j] != m_pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_arm();
    m_state = M_ARMED;
    m_q.delete();
    m_count = 0;
    m_quiet = 0;
  endtask

  task automatic model_step();
    int s;
    if (reset) begin
      m_state = M_IDLE; m_pat = 8'b0011_0110; m_len = 6; m_ovl = 1; m_tgt = 1;
      m_tmo = 0; m_count = 0; m_quiet = 0; m_pulse = 0; m_q.delete();
      return;
    end
    s = m_state;
    m_pulse = 0;
    if (s == M_IDLE && cfg_we) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : (cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
      m_ovl = cfg_overlap; m_tgt = cfg_target; m_tmo = cfg_timeout;
    end
    if (abort) begin
      m_state = M_IDLE;
    end else if (s == M_IDLE || s == M_DONE) begin
      if (start) model_arm();
    end else if (s == M_ARMED) begin
      bit hit = 0;
      if (din_valid) begin
        m_q.push_back(din);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        hit = tail_matches();
      end
      if (hit) begin
        if (m_count < 255) m_count++;
        m_quiet = 0;
        m_pulse = 1;
        if (!m_ovl) m_q.delete();
        if (m_tgt != 0 && m_count == m_tgt) m_state = M_DONE;
      end else begin
        m_quiet++;
        if (m_tmo != 0 && m_quiet == m_tmo) m_state = M_ERROR;
      end
    end
  endtask

  // One clock: update the model from the driven inputs, then compare after the edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("state_o", state_o, m_state);
    check("match_pulse", match_pulse, m_pulse);
    check("match_count", match_count, m_count);
    check("busy", busy, m_state == M_ARMED);
    check("done", done, m_state == M_DONE);
    check("timeout_err", timeout_err, m_state == M_ERROR);
  endtask

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic [7:0] tgt, input logic [15:0] tmo);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    cfg_timeout = tmo; cfg_we = 1'b1; cycle(); cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cycle(); abort = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din_valid = 1'b1; din = bits[i]; cycle();
    end
    din_valid = 1'b0; din = 1'b0;
  endtask

  initial begin
    // 1: defaults, single match to DONE
    do_reset();
    check("reset_state", state_o, 0);
    check("reset_count", match_count, 0);
    do_start();
    send_bits(32'b110110, 6);
    check("t1_pulse", match_pulse, 1);
    check("t1_done", done, 1);
    check("t1_count", match_count, 1);

    // 2: overlapping then non-overlapping, target 3
    do_abort();
    write_cfg(8'b0011_0110, 4'd6, 1'b1, 8'd3, 16'd0);
    do_start();
    send_bits(32'b110110110110, 12);
    check("t2_ovl_count", match_count, 3);
    check("t2_ovl_done", done, 1);
    do_abort();
    write_cfg(8'b0011_0110, 4'd6, 1'b0, 8'd3, 16'd0);
    do_start();
    send_bits(32'b110110110110, 12);
    check("t2_novl_count", match_count, 2);
    check("t2_novl_busy", busy, 1);

    // 3: timeout after 10 quiet ARMED cycles
    do_abort();
    write_cfg(8'b0011_0110, 4'd6, 1'b1, 8'd1, 16'd10);
    do_start();
    send_bits(32'd0, 9);
    check("t3_armed_at_9", state_o, 1);
    send_bits(32'd0, 1);
    check("t3_error", timeout_err, 1);
    do_start();
    check("t3_start_ignored", state_o, 3);
    do_abort();
    check("t3_abort_idle", state_o, 0);

    // 4: config ignored while ARMED; zero length clamps to one
    write_cfg(8'b0011_0110, 4'd6, 1'b1, 8'd1, 16'd0);
    do_start();
    write_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd1, 16'd0);
    send_bits(32'b110110, 6);
    check("t4_cfg_ignored", done, 1);
    do_abort();
    write_cfg(8'b0000_0001, 4'd0, 1'b1, 8'd2, 16'd0);
    do_start();
    send_bits(32'b1, 1);
    check("t4_len1_pulse", match_pulse, 1);
    do_abort();
    write_cfg(8'b0000_0001, 4'd15, 1'b1, 8'd1, 16'd0);

    // 5: abort on the final matching bit, start with abort
    write_cfg(8'b0011_0110, 4'd6, 1'b1, 8'd1, 16'd0);
    do_start();
    send_bits(32'b11011, 5);
    din_valid = 1'b1; din = 1'b0; abort = 1'b1; cycle();
    abort = 1'b0; din_valid = 1'b0;
    check("t5_no_pulse", match_pulse, 0);
    check("t5_idle", state_o, 0);
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
    check("t5_start_abort", state_o, 0);

    // 6: endless run saturates the counter, then reset mid-stream
    write_cfg(8'b0000_0001, 4'd0, 1'b1, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 300; i++) send_bits(32'b1, 1);
    check("t6_saturate", match_count, 255);
    check("t6_still_armed", busy, 1);
    din_valid = 1'b1; din = 1'b1; reset = 1'b1; cycle();
    reset = 1'b0; din_valid = 1'b0;
    check("t6_reset_count", match_count, 0);
    check("t6_reset_pulse", match_pulse, 0);
    do_start();
    send_bits(32'b110110, 6);
    check("t6_default_cfg", done, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_pattern = 8'($urandom());
      cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 3));
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_target  = 8'($urandom_range(0, 5));
      cfg_timeout = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 30));
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      din_valid   = ($urandom_range(0, 3) != 0);
      din         = 1'($urandom_range(0, 1));
      cycle();
    end
    reset = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
